vend_controller: RTL and testbench

VEND_CONTROLLER -- requirements
Module: vend_controller

---
 rtl/vend_controller.sv | 140 ++++++++++++++
 tb/tb_vend_controller.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/vend_controller.sv
// Vending machine controller: coin credit accumulation, product vend handshake
// with ack timeout, and unit-by-unit change return.
module vend_controller #(
  parameter int CW    = 6,
  parameter int P_DEF = 3,
  parameter int TMO   = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c5,
  input  logic          c10,
  input  logic          c25,
  input  logic          sel_v,
  input  logic [1:0]    sel_id,
  input  logic          cancel,
  input  logic          cfg_we,
  input  logic [1:0]    cfg_addr,
  input  logic [CW-1:0] cfg_price,
  output logic          vend_req,
  output logic [1:0]    vend_id,
  input  logic          vend_ack,
  output logic          chg_req,
  input  logic          chg_ack,
  output logic [CW-1:0] credit,
  output logic [1:0]    state,
  output logic          coin_rej,
  output logic          err
);

  typedef enum logic [1:0] {IDLE = 2'd0, CREDIT = 2'd1, VEND = 2'd2, CHANGE = 2'd3} state_t;

  localparam int TW = (TMO > 1) ? $clog2(TMO) : 1;

  state_t        st, st_nxt;
  logic [CW-1:0] credit_r, credit_nxt;
  logic [1:0]    vid_r, vid_nxt;
  logic [TW-1:0] cnt_r, cnt_nxt;
  logic          rej_r, rej_nxt, err_r, err_nxt;
  logic [CW-1:0] price [4];

  logic          coin_any, coin_ok, fundable;
  logic [CW+3:0] coin_sum;
  logic [CW-1:0] sel_price;

  // Widened so an overflowing coin sum is visible in the upper bits.
  function automatic logic [CW+3:0] coin_add(input logic [CW-1:0] base,
                                             input logic u1, input logic u2, input logic u5);
    logic [CW+3:0] s;
    s = {4'd0, base};
    if (u1) s = s + (CW+4)'(1);
    if (u2) s = s + (CW+4)'(2);
    if (u5) s = s + (CW+4)'(5);
    return s;
  endfunction

  assign coin_any  = c5 | c10 | c25;
  assign coin_sum  = coin_add(credit_r, c5, c10, c25);
  assign coin_ok   = coin_any && (coin_sum[CW+3:CW] == 4'd0);
  assign sel_price = price[sel_id];
  assign fundable  = sel_v && (sel_price != '0) && (credit_r >= sel_price);

  always_comb begin
    st_nxt     = st;
    credit_nxt = credit_r;
    vid_nxt    = vid_r;
    cnt_nxt    = cnt_r;
    rej_nxt    = 1'b0;
    err_nxt    = 1'b0;
    case (st)
      IDLE, CREDIT: begin
        if (coin_ok) begin
          credit_nxt = coin_sum[CW-1:0];
          st_nxt     = CREDIT;
        end else if (coin_any) begin
          rej_nxt = 1'b1;
        end
        if (st == CREDIT) begin
          if (fundable) begin
            credit_nxt = credit_nxt - sel_price;
            vid_nxt    = sel_id;
            cnt_nxt    = '0;
            st_nxt     = VEND;
          end else if (cancel) begin
            st_nxt = CHANGE;
          end
        end
      end
      VEND: begin
        rej_nxt = coin_any;
        if (vend_ack) begin
          st_nxt = (credit_r != '0) ? CHANGE : IDLE;
        end else if (cnt_r == TW'(TMO - 1)) begin
          // Dispenser never answered: refund the price and return it as change.
          credit_nxt = credit_r + price[vid_r];
          err_nxt    = 1'b1;
          st_nxt     = CHANGE;
        end else begin
          cnt_nxt = cnt_r + TW'(1);
        end
      end
      CHANGE: begin
        rej_nxt = coin_any;
        if (chg_ack) begin
          credit_nxt = credit_r - CW'(1);
          if (credit_r == CW'(1)) st_nxt = IDLE;
        end
      end
      default: st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      st       <= IDLE;
      credit_r <= '0;
      vid_r    <= '0;
      cnt_r    <= '0;
      rej_r    <= 1'b0;
      err_r    <= 1'b0;
      for (int i = 0; i < 4; i++) price[i] <= CW'(P_DEF);
    end else begin
      st       <= st_nxt;
      credit_r <= credit_nxt;
      vid_r    <= vid_nxt;
      cnt_r    <= cnt_nxt;
      rej_r    <= rej_nxt;
      err_r    <= err_nxt;
      if (cfg_we && (st == IDLE)) price[cfg_addr] <= cfg_price;
    end
  end

  assign vend_req = (st == VEND);
  assign chg_req  = (st == CHANGE);
  assign vend_id  = vid_r;
  assign credit   = credit_r;
  assign state    = st;
  assign coin_rej = rej_r;
  assign err      = err_r;

endmodule

// File: tb/tb_vend_controller.sv
// Bench for vend_controller: directed scenarios plus randomized traffic
// checked against a behavioural model of the vending rules.
module tb_vend_controller;
  localparam int CW    = 6;
  localparam int P_DEF = 3;
  localparam int TMO   = 4;
  localparam int LIM   = (1 << CW) - 1;

  logic          clk, rst, c5, c10, c25, sel_v, cancel, cfg_we, vend_ack, chg_ack;
  logic [1:0]    sel_id, cfg_addr;
  logic [CW-1:0] cfg_price;
  logic          vend_req, chg_req, coin_rej, err;
  logic [1:0]    vend_id, state;
  logic [CW-1:0] credit;

  int checks = 0;
  int errors = 0;

  // Reference model state (states numbered IDLE=0, CREDIT=1, VEND=2, CHANGE=3)
  int m_st, m_credit, m_vid, m_wait, m_vprice;
  bit m_rej, m_err;
  int m_price [4];

  vend_controller #(.CW(CW), .P_DEF(P_DEF), .TMO(TMO)) dut (
    .clk(clk), .rst(rst), .c5(c5), .c10(c10), .c25(c25),
    .sel_v(sel_v), .sel_id(sel_id), .cancel(cancel),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_price(cfg_price),
    .vend_req(vend_req), .vend_id(vend_id), .vend_ack(vend_ack),
    .chg_req(chg_req), .chg_ack(chg_ack),
    .credit(credit), .state(state), .coin_rej(coin_rej), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  // One clock: model computes the expected next state from the inputs the DUT
  // samples at this edge, then one-cycle pulses are cleared.
  task automatic cycle();
    int coins, ns, nc, p;
    bit rj, er;
    coins = (c5 ? 1 : 0) + (c10 ? 2 : 0) + (c25 ? 5 : 0);
    ns = m_st; nc = m_credit; rj = 0; er = 0;
    if (!rst) begin
      ns = 0; nc = 0; m_vid = 0; m_wait = 0;
      for (int i = 0; i < 4; i++) m_price[i] = P_DEF;
    end else begin
      case (m_st)
        0, 1: begin
          if (coins > 0) begin
            if (m_credit + coins <= LIM) begin nc = m_credit + coins; ns = 1; end
            else rj = 1;
          end
          if (m_st == 0 && cfg_we) m_price[cfg_addr] = int'(cfg_price);
          if (m_st == 1) begin
            p = m_price[sel_id];
            if (sel_v && p != 0 && m_credit >= p) begin
              nc = nc - p; m_vid = sel_id; m_vprice = p; m_wait = 0; ns = 2;
            end else if (cancel) ns = 3;
          end
        end
        2: begin
          rj = (coins > 0);
          if (vend_ack) ns = (m_credit > 0) ? 3 : 0;
          else begin
            m_wait++;
            if (m_wait >= TMO) begin nc = m_credit + m_vprice; er = 1; ns = 3; end
          end
        end
        default: begin
          rj = (coins > 0);
          if (chg_ack) begin nc = m_credit - 1; if (nc == 0) ns = 0; end
        end
      endcase
    end
    @(posedge clk); #1;
    m_st = ns; m_credit = nc; m_rej = rj; m_err = er;
    c5 = 0; c10 = 0; c25 = 0; sel_v = 0; cancel = 0; cfg_we = 0; vend_ack = 0; chg_ack = 0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin chg_ack = 1; cycle(); end
  endtask

  task automatic test_reset();
    rst = 0; cycle(); cycle(); rst = 1;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
    checks++; if (credit !== '0) begin errors++; $display("FAIL reset_credit got %0d want 0", credit); end
    checks++; if ({vend_req, chg_req, coin_rej, err} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b want 0000", {vend_req, chg_req, coin_rej, err}); end
    checks++; if (vend_id !== 2'd0) begin errors++; $display("FAIL reset_vend_id got %0d want 0", vend_id); end
  endtask

  task automatic test_exact_vend();
    c10 = 1; cycle();
    checks++; if (credit !== 6'd2 || state !== 2'd1) begin errors++; $display("FAIL exact_c10 got credit %0d state %0d want 2 1", credit, state); end
    c5 = 1; cycle();
    checks++; if (credit !== 6'd3) begin errors++; $display("FAIL exact_c5 got %0d want 3", credit); end
    sel_v = 1; sel_id = 2'd1; cycle();
    checks++; if (state !== 2'd2 || credit !== 6'd0) begin errors++; $display("FAIL exact_vend got state %0d credit %0d want 2 0", state, credit); end
    checks++; if (vend_req !== 1'b1 || vend_id !== 2'd1) begin errors++; $display("FAIL exact_req got req %0d id %0d want 1 1", vend_req, vend_id); end
    cycle();
    checks++; if (vend_req !== 1'b1 || vend_id !== 2'd1) begin errors++; $display("FAIL exact_hold got req %0d id %0d want 1 1", vend_req, vend_id); end
    vend_ack = 1; cycle();
    checks++; if (state !== 2'd0 || vend_req !== 1'b0) begin errors++; $display("FAIL exact_ack got state %0d req %0d want 0 0", state, vend_req); end
  endtask

  task automatic test_change();
    c25 = 1; cycle();
    checks++; if (credit !== 6'd5) begin errors++; $display("FAIL chg_c25 got %0d want 5", credit); end
    sel_v = 1; sel_id = 2'd0; cycle();
    checks++; if (credit !== 6'd2 || state !== 2'd2) begin errors++; $display("FAIL chg_vend got credit %0d state %0d want 2 2", credit, state); end
    vend_ack = 1; cycle();
    checks++; if (state !== 2'd3 || chg_req !== 1'b1) begin errors++; $display("FAIL chg_enter got state %0d req %0d want 3 1", state, chg_req); end
    chg_ack = 1; cycle();
    checks++; if (credit !== 6'd1 || state !== 2'd3) begin errors++; $display("FAIL chg_ack1 got credit %0d state %0d want 1 3", credit, state); end
    chg_ack = 1; cycle();
    checks++; if (credit !== 6'd0 || state !== 2'd0 || chg_req !== 1'b0) begin errors++; $display("FAIL chg_done got credit %0d state %0d req %0d want 0 0 0", credit, state, chg_req); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 12; i++) begin c25 = 1; cycle(); end
    checks++; if (credit !== 6'd60) begin errors++; $display("FAIL sat_fill got %0d want 60", credit); end
    c25 = 1; cycle();
    checks++; if (coin_rej !== 1'b1 || credit !== 6'd60) begin errors++; $display("FAIL sat_rej got rej %0d credit %0d want 1 60", coin_rej, credit); end
    cycle();
    checks++; if (coin_rej !== 1'b0) begin errors++; $display("FAIL sat_rej_pulse got %0d want 0", coin_rej); end
    cancel = 1; cycle();
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL sat_cancel got %0d want 3", state); end
    c5 = 1; cycle();
    checks++; if (coin_rej !== 1'b1 || credit !== 6'd60) begin errors++; $display("FAIL sat_coin_in_change got rej %0d credit %0d want 1 60", coin_rej, credit); end
    drain(60);
    checks++; if (state !== 2'd0 || credit !== 6'd0) begin errors++; $display("FAIL sat_drain got state %0d credit %0d want 0 0", state, credit); end
    c5 = 1; c10 = 1; cycle();
    checks++; if (credit !== 6'd3 || state !== 2'd1) begin errors++; $display("FAIL sat_multi_coin got credit %0d state %0d want 3 1", credit, state); end
    cancel = 1; cycle(); drain(3);
  endtask

  task automatic test_timeout();
    c25 = 1; cycle();
    sel_v = 1; sel_id = 2'd3; cycle();
    for (int i = 0; i < TMO - 1; i++) begin
      cycle();
      checks++; if (state !== 2'd2 || err !== 1'b0) begin errors++; $display("FAIL tmo_wait%0d got state %0d err %0d want 2 0", i, state, err); end
    end
    cycle();
    checks++; if (err !== 1'b1 || state !== 2'd3) begin errors++; $display("FAIL tmo_expire got err %0d state %0d want 1 3", err, state); end
    checks++; if (credit !== 6'd5 || vend_req !== 1'b0) begin errors++; $display("FAIL tmo_refund got credit %0d req %0d want 5 0", credit, vend_req); end
    cycle();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL tmo_err_pulse got %0d want 0", err); end
    drain(5);
    c25 = 1; cycle();
    sel_v = 1; sel_id = 2'd3; cycle();
    for (int i = 0; i < TMO - 1; i++) cycle();
    vend_ack = 1; cycle();
    checks++; if (err !== 1'b0 || state !== 2'd3 || credit !== 6'd2) begin errors++; $display("FAIL tmo_ack_prio got err %0d state %0d credit %0d want 0 3 2", err, state, credit); end
    drain(2);
  endtask

  task automatic test_config();
    cfg_we = 1; cfg_addr = 2'd2; cfg_price = '0; cycle();
    c25 = 1; cycle();
    sel_v = 1; sel_id = 2'd2; cycle();
    checks++; if (state !== 2'd1 || credit !== 6'd5) begin errors++; $display("FAIL cfg_free_ignored got state %0d credit %0d want 1 5", state, credit); end
    cfg_we = 1; cfg_addr = 2'd0; cfg_price = 6'd1; cycle();
    sel_v = 1; sel_id = 2'd0; cycle();
    checks++; if (state !== 2'd2 || credit !== 6'd2) begin errors++; $display("FAIL cfg_dropped got state %0d credit %0d want 2 2", state, credit); end
    vend_ack = 1; cycle(); drain(2);
    cfg_we = 1; cfg_addr = 2'd2; cfg_price = 6'd3; cycle();
    c5 = 1; cycle();
    sel_v = 1; sel_id = 2'd1; cycle();
    checks++; if (state !== 2'd1 || credit !== 6'd1) begin errors++; $display("FAIL cfg_short_funds got state %0d credit %0d want 1 1", state, credit); end
    cancel = 1; cycle(); drain(1);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL cfg_cancel_done got %0d want 0", state); end
  endtask

  task automatic test_reset_mid_vend();
    cfg_we = 1; cfg_addr = 2'd1; cfg_price = 6'd7; cycle();
    c25 = 1; cycle(); c25 = 1; cycle();
    sel_v = 1; sel_id = 2'd3; cycle();
    checks++; if (state !== 2'd2 || vend_id !== 2'd3) begin errors++; $display("FAIL rstv_vend got state %0d id %0d want 2 3", state, vend_id); end
    rst = 0; cycle(); rst = 1;
    checks++; if (state !== 2'd0 || credit !== '0) begin errors++; $display("FAIL rstv_state got state %0d credit %0d want 0 0", state, credit); end
    checks++; if ({vend_req, chg_req, coin_rej, err} !== 4'b0 || vend_id !== 2'd0) begin errors++; $display("FAIL rstv_outputs got %b id %0d want 0000 0", {vend_req, chg_req, coin_rej, err}, vend_id); end
    c25 = 1; cycle();
    sel_v = 1; sel_id = 2'd1; cycle();
    checks++; if (credit !== 6'd2 || state !== 2'd2) begin errors++; $display("FAIL rstv_price_default got credit %0d state %0d want 2 2", credit, state); end
    vend_ack = 1; cycle(); drain(2);
  endtask

  task automatic test_random();
    int k;
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
      k = $urandom_range(0, 5);
      case (k)
        0: begin c5 = 1'($urandom_range(0, 1)); c10 = 1'($urandom_range(0, 1)); c25 = 1'($urandom_range(0, 1)); end
        1: begin sel_v = 1; sel_id = 2'($urandom_range(0, 3)); cancel = ($urandom_range(0, 3) == 0); end
        2: cancel = 1;
        3: begin cfg_we = 1; cfg_addr = 2'($urandom_range(0, 3)); cfg_price = CW'($urandom_range(0, 8)); end
        default: ;
      endcase
      vend_ack = ($urandom_range(0, 3) == 0);
      chg_ack  = ($urandom_range(0, 1) == 0);
      cycle();
      checks++; if (state !== 2'(m_st)) begin errors++; $display("FAIL rnd_state n=%0d got %0d want %0d", n, state, m_st); end
      checks++; if (credit !== CW'(m_credit)) begin errors++; $display("FAIL rnd_credit n=%0d got %0d want %0d", n, credit, m_credit); end
      checks++; if (vend_req !== (m_st == 2) || chg_req !== (m_st == 3)) begin errors++; $display("FAIL rnd_req n=%0d got %0d%0d want st %0d", n, vend_req, chg_req, m_st); end
      checks++; if (vend_id !== 2'(m_vid)) begin errors++; $display("FAIL rnd_vend_id n=%0d got %0d want %0d", n, vend_id, m_vid); end
      checks++; if (coin_rej !== m_rej || err !== m_err) begin errors++; $display("FAIL rnd_pulses n=%0d got rej %0d err %0d want %0d %0d", n, coin_rej, err, m_rej, m_err); end
    end
    rst = 1;
  endtask

  initial begin
    rst = 0; c5 = 0; c10 = 0; c25 = 0; sel_v = 0; sel_id = 0; cancel = 0;
    cfg_we = 0; cfg_addr = 0; cfg_price = 0; vend_ack = 0; chg_ack = 0;
    m_st = 0; m_credit = 0; m_vid = 0; m_wait = 0; m_vprice = 0; m_rej = 0; m_err = 0;
    for (int i = 0; i < 4; i++) m_price[i] = P_DEF;
    @(negedge clk);
    test_reset();
    test_exact_vend();
    test_change();
    test_saturation();
    test_timeout();
    test_config();
    test_reset_mid_vend();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
